width_upconv_hs: RTL and testbench
==================================

Name: width_upconv_hs

Overview:
- Parametrised successor to the fixed 8b-to-32b converter.
- Packs RATIO narrow beats of IN_W bits into one IN_W*RATIO word on a single clock, so the upstream side no longer needs a divided clock.
- Adds a ready/valid handshake on both sides, downstream backpressure, selectable lane order, and a flush that emits a partial word with a per-lane keep mask.
- Sits between the byte-wide front end and the word-wide datapath.

Parameters:
- IN_W, 8, width of one input beat in bits.
- RATIO, 4, beats per output word; legal values 2..16.
- MSB_FIRST, 1, 1 = first beat lands in the most-significant lane; 0 = first beat lands in the least-significant lane.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  IN_W  input beat.
- valid_in  in  1  data_in is valid.
- flush_in  in  1  close the current word after this cycle's beat, if any.
- ready_in  out  1  block can accept a beat or flush this cycle.
- data_out  out  IN_W*RATIO  packed word.
- keep_out  out  RATIO  keep_out[j]=1 when lane data_out[IN_W*j +: IN_W] holds a real beat.
- valid_out  out  1  data_out and keep_out are valid.
- ready_out  in  1  downstream accepts the word this cycle.

Behaviour:
- Storage:
  - Accumulator: RATIO lanes, a lane counter idx (0..RATIO-1), a lane-valid mask and a pending flag.
  - Output register: data_out, keep_out, valid_out.
- Reset (reset_L low, asynchronous):
  - data_out=0, keep_out=0, valid_out=0.
  - idx=0, accumulator and mask cleared, pending=0.
  - ready_in=0 while reset_L is low; it becomes 1 in the first cycle after release.
- ready_in = reset_L & !pending (combinational).
- Accept: a beat is accepted when valid_in && ready_in.
  - The beat is written to logical lane idx and that lane's mask bit is set; idx increments.
  - Physical lane mapping: MSB_FIRST=1 puts logical lane k in physical lane RATIO-1-k; MSB_FIRST=0 puts it in physical lane k.
- Flush: flush_in is qualified by ready_in and ignored when ready_in=0.
- Word completion on an edge occurs when any of these holds:
  - an accepted beat fills idx==RATIO-1;
  - flush_in=1 together with an accepted beat;
  - flush_in=1 with no beat and idx>0.
- flush_in with idx==0 and no beat is a no-op.
- Unfilled lanes of a completed word carry data 0 and keep 0.
- Output register is free when valid_out==0, or valid_out && ready_out on the same edge.
- On completion:
  - Output free: the word and mask load into the output register on that edge, and idx and mask clear. Latency is 1 cycle: last beat at edge N gives valid_out=1 from edge N on.
  - Output not free: the completed word is held in the accumulator, pending=1, and ready_in drops.
- Pending: while pending=1, the held word loads into the output register on the first edge the output is free; pending and idx clear on that edge. ready_in returns to 1 the cycle after.
- Output hold: valid_out, data_out and keep_out stay stable until the edge where ready_out=1; then valid_out clears unless a new word loads on the same edge.
- Back-to-back: with ready_out held at 1, a continuous stream gives a full word every RATIO cycles with no bubbles.
- Word order is strictly preserved; no words are dropped or duplicated.
- Reset mid-word discards every partial and pending word.
- State machine: ACC (filling, ready_in=1), PEND (completed word blocked, ready_in=0). Transitions:
  - ACC to PEND on completion while the output is not free.
  - PEND to ACC when the output becomes free.

Test Plan:
- Reset check: hold reset_L=0 for 3 cycles with valid_in toggling -> data_out=0, keep_out=0, valid_out=0, ready_in=0; after release, ready_in=1.
- Full word, MSB_FIRST=1, ready_out=1: send 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles -> data_out=0xAABBCCDD, keep_out=4'b1111, valid_out high exactly 1 cycle, starting the cycle after 0xDD.
- Lane order, MSB_FIRST=0, same stimulus -> data_out=0xDDCCBBAA, keep_out=4'b1111.
- Partial flush, MSB_FIRST=1: send 0x11, then 0x22 with flush_in=1 -> data_out=0x11220000, keep_out=4'b1100. A following 0x33,0x44,0x55,0x66 -> 0x33445566.
- Backpressure: ready_out=0, stream 0x01..0x08 -> word 0x01020304 held on output; after 0x08, ready_in=0 and the stream stalls. Raise ready_out -> 0x01020304 then 0x05060708 on consecutive accepts; ready_in=1 again.
- Reset mid-word: accept 0xA1,0xA2, pulse reset_L low, then send 0xB1..0xB4 -> single output 0xB1B2B3B4, keep_out=4'b1111, with no trace of 0xA1/0xA2.

Source files
------------

// File: rtl/width_upconv_hs.sv
// Narrow-to-wide beat packer with ready/valid on both sides, flush of partial
// words with a per-lane keep mask, and a one-word skid for downstream stalls.
module width_upconv_hs #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  valid_in,
  input  logic                  flush_in,
  output logic                  ready_in,
  output logic [IN_W*RATIO-1:0] data_out,
  output logic [RATIO-1:0]      keep_out,
  output logic                  valid_out,
  input  logic                  ready_out
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0] mask_q, mask_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic [RATIO-1:0] keep_out_q, keep_out_d;
  logic             valid_out_q, valid_out_d;

  logic             accept;
  logic             flush_go;
  logic             complete;
  logic             out_free;
  logic [RATIO-1:0] lane_hit;
  logic [OUT_W-1:0] word_ins;
  logic [RATIO-1:0] mask_ins;

  assign ready_in = reset_L & (state_q == ST_ACC);
  assign accept   = valid_in & ready_in;
  assign flush_go = flush_in & ready_in;
  assign out_free = ~valid_out_q | ready_out;

  // A flush with nothing buffered and no beat this cycle must not emit an empty word.
  assign complete = (accept & ((idx_q == LAST_IDX) | flush_in)) |
                    (flush_go & ~accept & (idx_q != '0));

  // Each physical lane knows which logical beat index lands in it.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    localparam int LOGICAL = (MSB_FIRST != 0) ? (RATIO - 1 - gi) : gi;
    assign lane_hit[gi] = accept & (idx_q == IDX_W'(LOGICAL));
    assign word_ins[IN_W*gi +: IN_W] = lane_hit[gi] ? data_in : acc_q[IN_W*gi +: IN_W];
    assign mask_ins[gi] = lane_hit[gi] | mask_q[gi];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    valid_out_d = valid_out_q;

    if (valid_out_q && ready_out) begin
      valid_out_d = 1'b0;
    end

    case (state_q)
      ST_ACC: begin
        if (complete) begin
          if (out_free) begin
            data_out_d  = word_ins;
            keep_out_d  = mask_ins;
            valid_out_d = 1'b1;
            acc_d       = '0;
            mask_d      = '0;
          end else begin
            // Park the finished word in the accumulator until the output drains.
            acc_d   = word_ins;
            mask_d  = mask_ins;
            state_d = ST_PEND;
          end
          idx_d = '0;
        end else if (accept) begin
          acc_d  = word_ins;
          mask_d = mask_ins;
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      ST_PEND: begin
        if (out_free) begin
          data_out_d  = acc_q;
          keep_out_d  = mask_q;
          valid_out_d = 1'b1;
          acc_d       = '0;
          mask_d      = '0;
          idx_d       = '0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_ACC;
      idx_q       <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_width_upconv_hs.sv
// Scoreboard bench: two converters (MSB-first and LSB-first) share one stimulus
// stream; expected words are queued as beats are accepted and popped on output.
module tb_width_upconv_hs;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             reset_L;
  logic [IN_W-1:0]  data_in;
  logic             valid_in;
  logic             flush_in;
  logic             ready_out;

  logic             ready_in_m, ready_in_l;
  logic [OUT_W-1:0] data_out_m, data_out_l;
  logic [RATIO-1:0] keep_out_m, keep_out_l;
  logic             valid_out_m, valid_out_l;

  width_upconv_hs #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .flush_in(flush_in), .ready_in(ready_in_m), .data_out(data_out_m),
    .keep_out(keep_out_m), .valid_out(valid_out_m), .ready_out(ready_out)
  );

  width_upconv_hs #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .flush_in(flush_in), .ready_in(ready_in_l), .data_out(data_out_l),
    .keep_out(keep_out_l), .valid_out(valid_out_l), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer_m = 0;
  bit rand_ro  = 1'b0;

  logic [OUT_W+RATIO-1:0] q_m[$];
  logic [OUT_W+RATIO-1:0] q_l[$];
  logic [IN_W-1:0]        beats[RATIO];
  int                     n_beats = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W+RATIO-1:0] pack(input bit msb);
    logic [OUT_W-1:0] d = '0;
    logic [RATIO-1:0] k = '0;
    for (int i = 0; i < n_beats; i++) begin
      int lane = msb ? (RATIO - 1 - i) : i;
      d[lane*IN_W +: IN_W] = beats[i];
      k[lane] = 1'b1;
    end
    return {k, d};
  endfunction

  task automatic push_word();
    q_m.push_back(pack(1'b1));
    q_l.push_back(pack(1'b0));
    n_beats = 0;
  endtask

  // Present one beat; returns at posedge+1 after it is accepted.
  task automatic send(input logic [IN_W-1:0] b, input logic fl, output int stalls);
    stalls   = 0;
    data_in  = b;
    valid_in = 1'b1;
    flush_in = fl;
    @(negedge clk);
    while (!ready_in_m) begin
      stalls++;
      if (stalls > 500) begin
        check_eq("send_timeout", 64'(stalls), 64'd0);
        valid_in = 1'b0;
        flush_in = 1'b0;
        return;
      end
      @(negedge clk);
    end
    beats[n_beats] = b;
    n_beats++;
    if (fl || n_beats == RATIO) push_word();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic flush_only();
    int g = 0;
    valid_in = 1'b0;
    flush_in = 1'b1;
    @(negedge clk);
    while (!ready_in_m && g < 500) begin
      g++;
      @(negedge clk);
    end
    check_eq("flush_timeout", 64'(g >= 500), 64'd0);
    if (n_beats > 0) push_word();
    @(posedge clk);
    #1;
    flush_in = 1'b0;
  endtask

  // Output monitor: scoreboard pop on each transfer plus hold-stability under backpressure.
  logic             pv_m, pv_l, pro;
  logic [OUT_W-1:0] pd_m, pd_l;
  logic [RATIO-1:0] pk_m, pk_l;
  initial begin
    logic [OUT_W+RATIO-1:0] e;
    pv_m = 1'b0; pv_l = 1'b0; pro = 1'b1;
    pd_m = '0; pd_l = '0; pk_m = '0; pk_l = '0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        pv_m = 1'b0;
        pv_l = 1'b0;
      end else begin
        if (pv_m && !pro) begin
          check_eq("hold_valid_m", 64'(valid_out_m), 64'd1);
          check_eq("hold_data_m", 64'({keep_out_m, data_out_m}), 64'({pk_m, pd_m}));
        end
        if (pv_l && !pro) begin
          check_eq("hold_data_l", 64'({keep_out_l, data_out_l}), 64'({pk_l, pd_l}));
        end
        if (valid_out_m && ready_out) begin
          n_xfer_m++;
          if (q_m.size() == 0) check_eq("unexpected_word_m", 64'(data_out_m), 64'd0);
          else begin
            e = q_m.pop_front();
            check_eq("word_m", 64'({keep_out_m, data_out_m}), 64'(e));
          end
        end
        if (valid_out_l && ready_out) begin
          if (q_l.size() == 0) check_eq("unexpected_word_l", 64'(data_out_l), 64'd0);
          else begin
            e = q_l.pop_front();
            check_eq("word_l", 64'({keep_out_l, data_out_l}), 64'(e));
          end
        end
        pv_m = valid_out_m; pd_m = data_out_m; pk_m = keep_out_m;
        pv_l = valid_out_l; pd_l = data_out_l; pk_l = keep_out_l;
        pro  = ready_out;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ro) ready_out = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int st;
    int tot;
    int x0;
    reset_L   = 1'b1;
    valid_in  = 1'b0;
    flush_in  = 1'b0;
    data_in   = '0;
    ready_out = 1'b1;
    #1 reset_L = 1'b0;

    // Reset with valid_in toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      valid_in = ~valid_in;
      data_in  = 8'h5A;
      @(negedge clk);
      check_eq("rst_valid_out", 64'(valid_out_m), 64'd0);
      check_eq("rst_data_out", 64'(data_out_m), 64'd0);
      check_eq("rst_keep_out", 64'(keep_out_m), 64'd0);
      check_eq("rst_ready_in", 64'(ready_in_m), 64'd0);
      check_eq("rst_valid_out_l", 64'(valid_out_l), 64'd0);
    end
    valid_in = 1'b0;
    reset_L  = 1'b1;
    #1;
    check_eq("rel_ready_in", 64'(ready_in_m), 64'd1);
    @(posedge clk);
    #1;

    // Full word, both lane orders
    send(8'hAA, 1'b0, st);
    send(8'hBB, 1'b0, st);
    send(8'hCC, 1'b0, st);
    check_eq("pre_valid", 64'(valid_out_m), 64'd0);
    send(8'hDD, 1'b0, st);
    check_eq("full_valid", 64'(valid_out_m), 64'd1);
    check_eq("full_data_m", 64'(data_out_m), 64'hAABBCCDD);
    check_eq("full_data_l", 64'(data_out_l), 64'hDDCCBBAA);
    check_eq("full_keep", 64'(keep_out_m), 64'hF);
    @(posedge clk);
    #1;
    check_eq("one_cycle_valid", 64'(valid_out_m), 64'd0);

    // Partial flush, then a full word
    send(8'h11, 1'b0, st);
    send(8'h22, 1'b1, st);
    check_eq("pflush_data_m", 64'(data_out_m), 64'h11220000);
    check_eq("pflush_keep_m", 64'(keep_out_m), 64'hC);
    check_eq("pflush_data_l", 64'(data_out_l), 64'h00002211);
    check_eq("pflush_keep_l", 64'(keep_out_l), 64'h3);
    send(8'h33, 1'b0, st);
    send(8'h44, 1'b0, st);
    send(8'h55, 1'b0, st);
    send(8'h66, 1'b0, st);
    check_eq("after_flush_data", 64'(data_out_m), 64'h33445566);

    // Flush on an empty accumulator is a no-op; flush-only with one beat emits it
    flush_only();
    check_eq("flush_empty_noop", 64'(valid_out_m), 64'd0);
    send(8'h77, 1'b0, st);
    flush_only();
    check_eq("flush_only_data", 64'(data_out_m), 64'h77000000);
    check_eq("flush_only_keep", 64'(keep_out_m), 64'h8);
    @(posedge clk);
    #1;

    // Backpressure
    ready_out = 1'b0;
    tot = 0;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0, st);
      tot += st;
    end
    check_eq("bp_no_stall_before_full", 64'(tot), 64'd0);
    check_eq("bp_ready_in_low", 64'(ready_in_m), 64'd0);
    check_eq("bp_held_data", 64'(data_out_m), 64'h01020304);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_stall_ready_in", 64'(ready_in_m), 64'd0);
    end
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_second_data", 64'(data_out_m), 64'h05060708);
    check_eq("bp_second_valid", 64'(valid_out_m), 64'd1);
    check_eq("bp_ready_in_back", 64'(ready_in_m), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream: no bubbles with ready_out held
    tot = 0;
    x0 = n_xfer_m;
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0, st);
      tot += st;
    end
    @(posedge clk);
    #1;
    check_eq("b2b_stalls", 64'(tot), 64'd0);
    check_eq("b2b_words", 64'(n_xfer_m - x0), 64'd2);

    // Reset mid-word discards the partial word
    send(8'hA1, 1'b0, st);
    send(8'hA2, 1'b0, st);
    @(negedge clk);
    reset_L = 1'b0;
    n_beats = 0;
    #1;
    check_eq("mid_rst_ready_in", 64'(ready_in_m), 64'd0);
    check_eq("mid_rst_valid", 64'(valid_out_m), 64'd0);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    send(8'hB1, 1'b0, st);
    send(8'hB2, 1'b0, st);
    send(8'hB3, 1'b0, st);
    send(8'hB4, 1'b0, st);
    check_eq("mid_rst_data", 64'(data_out_m), 64'hB1B2B3B4);
    check_eq("mid_rst_keep", 64'(keep_out_m), 64'hF);
    @(posedge clk);
    #1;

    // Random stream with random backpressure and flushes
    rand_ro = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 5) == 0), st);
    end
    flush_only();
    rand_ro = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 50 && (q_m.size() != 0 || q_l.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq("drain_q_m", 64'(q_m.size()), 64'd0);
    check_eq("drain_q_l", 64'(q_l.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
